// File: rtl/apb_master_arb_pkg.sv
// Shared types and default parameters for the round-robin APB master.
// Optional feature macro: APB_MASTER_ARB_TIMEOUT_EN (see apb_master_arb.sv).
package apb_master_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    localparam int unsigned DEF_AWIDTH         = 4;
    localparam int unsigned DEF_DWIDTH         = 8;
    localparam int unsigned DEF_NREQ           = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/apb_master_arb_rr.sv
// Combinational round-robin picker: search starts one past the last granted index.
module rr_arbiter
    import apb_master_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin arbiter + APB master sharing one register slave among NREQ requesters.
// Define APB_MASTER_ARB_TIMEOUT_EN to bound ACCESS at TIMEOUT_CYCLES PREADY-low cycles.
module apb_master_arb
    import apb_master_arb_pkg::*;
#(
    parameter int unsigned AWIDTH         = DEF_AWIDTH,
    parameter int unsigned DWIDTH         = DEF_DWIDTH,
    parameter int unsigned NREQ           = DEF_NREQ,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*AWIDTH-1:0]   req_addr,
    input  logic [NREQ*DWIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DWIDTH-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [AWIDTH-1:0]        PADDR,
    output logic [DWIDTH-1:0]        PWDATA,
    input  logic [DWIDTH-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("apb_master_arb: NREQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_arb: TIMEOUT_CYCLES must be at least 1");
    end

    state_e        state_q;
    logic [IW-1:0] ptr_q;     // last granted index, also the owner of the transfer in flight
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            timed_out;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign req_ready = (state_q == StIdle) ? arb_gnt : '0;

`ifdef APB_MASTER_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_q;

    // Ends the transfer in the TIMEOUT_CYCLES-th consecutive PREADY-low ACCESS cycle.
    assign timed_out = (state_q == StAccess) && !PREADY && (wait_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_q <= '0;
        end else if (state_q == StSetup) begin
            wait_q <= '0;
        end else if (state_q == StAccess && !PREADY) begin
            wait_q <= wait_q + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= StIdle;
            ptr_q     <= IW'(NREQ - 1);
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        state_q <= StSetup;
                        ptr_q   <= arb_idx;
                        PSEL    <= 1'b1;
                        PWRITE  <= req_write[arb_idx];
                        PADDR   <= req_addr[arb_idx*AWIDTH +: AWIDTH];
                        PWDATA  <= req_wdata[arb_idx*DWIDTH +: DWIDTH];
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    PENABLE <= 1'b1;
                end
                StAccess: begin
                    if (PREADY || timed_out) begin
                        state_q   <= StIdle;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= NREQ'(1) << ptr_q;
                        rsp_err   <= PREADY ? PSLVERR : 1'b1;
                        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb with a small behavioural APB register slave.
module tb_apb_master_arb;

    localparam int NREQ = 2;
    localparam int AW   = 4;
    localparam int DW   = 8;

    logic              PCLK    = 1'b0;
    logic              PRESETn = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW-1:0]     PRDATA;
    logic              PREADY, PSLVERR;

    apb_master_arb #(
        .AWIDTH         (AW),
        .DWIDTH         (DW),
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int            req;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } exp_t;

    cmd_t          cmd_q[NREQ][$];
    exp_t          exp_q[$];
    logic [DW-1:0] exp_mem[16];
    logic [DW-1:0] slave_mem[16];

    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;
    int              acc_cyc = 0;
    int              wait_n = 0;
    int              acc_cnt = 0;
    logic            stuck = 1'b0;
    logic            busy  = 1'b0;
    logic [NREQ-1:0] accepted = '0;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Register slave: address 0xF is unmapped; PSLVERR is deliberately noisy while not ready.
    always @(posedge PCLK) begin
        if (!PRESETn) begin
            acc_cnt <= 0;
            for (int k = 0; k < 16; k++) slave_mem[k] <= (k == 5) ? 8'h3C : 8'h00;
        end else begin
            if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
            else if (!PENABLE)              acc_cnt <= 0;
            if (PSEL && PENABLE && PREADY && PWRITE && PADDR != 4'hF) slave_mem[PADDR] <= PWDATA;
        end
    end

    assign PREADY  = PSEL && PENABLE && !stuck && (acc_cnt >= wait_n);
    assign PRDATA  = (PSEL && PADDR != 4'hF) ? slave_mem[PADDR] : 8'h00;
    assign PSLVERR = PSEL && (PADDR == 4'hF || !PREADY);

    // Requester driver: keeps req_valid high until accepted, then loads the next queued command.
    initial begin : drv
        cmd_t c;
        forever begin
            @(posedge PCLK);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && accepted[i]) begin
                    req_valid[i] = 1'b0;
                    accepted[i]  = 1'b0;
                end
                if (!req_valid[i] && cmd_q[i].size() > 0) begin
                    c = cmd_q[i].pop_front();
                    req_write[i]           = c.write;
                    req_addr[i*AW +: AW]   = c.addr;
                    req_wdata[i*DW +: DW]  = c.data;
                    req_valid[i]           = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each response, checks grant legality on each accept.
    initial begin : mon
        exp_t            e;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge PCLK);
            if (PRESETn) begin
                if (rsp_valid != '0) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL rsp_unexpected: rsp_valid=%b required none", rsp_valid);
                    end else begin
                        e = exp_q.pop_front();
                        oh = '0;
                        oh[e.req] = 1'b1;
                        if (rsp_valid !== oh || rsp_rdata !== e.rdata || rsp_err !== e.err
                            || (cyc - acc_cyc) != e.lat) begin
                            bad++;
                            $display("FAIL rsp: got valid=%b rdata=%h err=%b lat=%0d, need valid=%b rdata=%h err=%b lat=%0d",
                                     rsp_valid, rsp_rdata, rsp_err, cyc - acc_cyc,
                                     oh, e.rdata, e.err, e.lat);
                        end
                    end
                    busy = 1'b0;
                end
                if (req_ready != '0) begin
                    total++;
                    if (busy || !$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) begin
                        bad++;
                        $display("FAIL grant: req_ready=%b req_valid=%b busy=%b, need one-hot valid grant while idle",
                                 req_ready, req_valid, busy);
                    end
                    busy    = 1'b1;
                    acc_cyc = cyc;
                    accepted = accepted | req_ready;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int k = 0; k < 16; k++) exp_mem[k] = 8'h00;
        exp_mem[5] = 8'h3C;
    endtask

    task automatic push_cmd(input int r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int lat);
        cmd_t c;
        exp_t e;
        c.write = w;
        c.addr  = a;
        c.data  = d;
        e.req   = r;
        e.lat   = lat;
        e.err   = (a == 4'hF);
        e.rdata = (w || a == 4'hF) ? 8'h00 : exp_mem[a];
        if (w && a != 4'hF) exp_mem[a] = d;
        cmd_q[r].push_back(c);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy || req_valid != '0
                || cmd_q[0].size() != 0 || cmd_q[1].size() != 0) && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL drain: %0d responses still pending after %0d cycles, need 0",
                     exp_q.size(), budget);
        end
        @(negedge PCLK);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge PCLK);
        total++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, need all zero",
                     {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err});
        end
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        total++;
        if (req_ready !== '0 || PSEL !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: req_ready=%b PSEL=%b, need 00 and 0", req_ready, PSEL);
        end
    endtask

    task automatic test_write_basic();
        int k = 0;
        wait_n = 0;
        push_cmd(0, 1'b1, 4'h0, 8'hA5, 3);
        while (req_ready[0] !== 1'b1 && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL write_accept: req_ready=%b, need 01", req_ready);
        end
        @(negedge PCLK);
        total++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101) begin
            bad++;
            $display("FAIL write_setup: PSEL/PENABLE/PWRITE=%b, need 101", {PSEL, PENABLE, PWRITE});
        end
        @(negedge PCLK);
        total++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 4'h0, 8'hA5}) begin
            bad++;
            $display("FAIL write_access: sel/en/wr=%b addr=%h wdata=%h, need 111 0 a5",
                     {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
        end
        wait_drain(20);
    endtask

    task automatic test_read_basic();
        int k = 0;
        wait_n = 0;
        push_cmd(1, 1'b0, 4'h5, 8'h00, 3);
        while (req_ready[1] !== 1'b1 && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL read_accept: req_ready=%b, need 10", req_ready);
        end
        @(negedge PCLK);
        @(negedge PCLK);
        total++;
        if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b110, 4'h5}) begin
            bad++;
            $display("FAIL read_access: sel/en/wr=%b addr=%h, need 110 5", {PSEL, PENABLE, PWRITE}, PADDR);
        end
        wait_drain(20);
    endtask

    task automatic test_round_robin();
        wait_n = 0;
        // Pointer sits at 1 here, so requester 0 wins first and grants alternate.
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 1'b1, 4'(i + 1), 8'(8'h10 + i), 3);
            push_cmd(1, 1'b0, 4'(i + 1), 8'h00, 3);
        end
        wait_drain(100);
    endtask

    task automatic test_wait_err();
        wait_n = 3;
        push_cmd(0, 1'b0, 4'hF, 8'h00, 6);
        wait_drain(40);
        wait_n = 2;
        push_cmd(1, 1'b1, 4'h2, 8'h77, 5);
        wait_drain(40);
        wait_n = 0;
        push_cmd(0, 1'b0, 4'h2, 8'h00, 3);
        wait_drain(40);
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        int   k = 0;
        stuck   = 1'b1;
        c.write = 1'b0;
        c.addr  = 4'h4;
        c.data  = 8'h00;
        cmd_q[0].push_back(c);
        while (PENABLE !== 1'b1 && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        total++;
        if (PENABLE !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_access: PENABLE=%b, need 1", PENABLE);
        end
        @(posedge PCLK);
        #3 PRESETn = 1'b0;
        #1;
        total++;
        if ({PSEL, PENABLE, rsp_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid_async: PSEL/PENABLE/rsp_valid=%b, need 0000", {PSEL, PENABLE, rsp_valid});
        end
        busy     = 1'b0;
        accepted = '0;
        stuck    = 1'b0;
        model_reset();
        repeat (2) @(negedge PCLK);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        // Both contend at once; reset pointer must favour requester 0.
        push_cmd(0, 1'b1, 4'h7, 8'h5A, 3);
        push_cmd(1, 1'b1, 4'h8, 8'h6B, 3);
        wait_drain(40);
        push_cmd(1, 1'b0, 4'h7, 8'h00, 3);
        wait_drain(40);
    endtask

`ifdef APB_MASTER_ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        cmd_t c;
        stuck = 1'b1;
        for (int i = 0; i < 2; i++) begin
            c.write = (i == 0);
            c.addr  = 4'(3 + i);
            c.data  = 8'hEE;
            cmd_q[i].push_back(c);
            e.req   = i;
            e.rdata = 8'h00;
            e.err   = 1'b1;
            e.lat   = 6;
            exp_q.push_back(e);
        end
        wait_drain(60);
        stuck = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_round_robin();
        test_wait_err();
        test_reset_mid();
`ifdef APB_MASTER_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Round-robin arbiter and APB master that shares one APB register slave (write registers, read registers, address decoder, PSLVERR on unmapped addresses) between NREQ local requesters. Each requester issues single read or write commands. The block grants one command at a time, drives the APB SETUP/ACCESS phases, waits for PREADY, and returns read data and error status to the granted requester. It sits between the control logic (sequencers, host bridge) and the register slave.

## Interface
- AWIDTH, 4, APB address width
- DWIDTH, 8, APB data width
- NREQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 15, maximum ACCESS cycles without PREADY (used only with timeout compiled in)

- PCLK  in  1  APB clock; all logic rising-edge
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester command pending; held until accepted
- req_write  in  NREQ  per-requester 1=write, 0=read
- req_addr  in  NREQ*AWIDTH  flattened addresses; requester i at [i*AWIDTH +: AWIDTH]
- req_wdata  in  NREQ*DWIDTH  flattened write data, same packing
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DWIDTH  read data, valid with rsp_valid (0 for writes)
- rsp_err  out  1  PSLVERR/timeout status, valid with rsp_valid
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR  out  AWIDTH; PWDATA  out  DWIDTH
- PRDATA  in  DWIDTH; PREADY  in  1; PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- In IDLE with any req_valid set, the arbiter grants requester g. req_ready[g] is combinational in that cycle (state==IDLE & grant). PWRITE/PADDR/PWDATA are registered from requester g. Next state is SETUP.
- SETUP: PSEL=1, PENABLE=0, for exactly one cycle. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Address, data and PWRITE are stable. The FSM stays in ACCESS while PREADY=0. On PREADY=1 it captures PRDATA (reads) and PSLVERR, deasserts PSEL/PENABLE next cycle, pulses rsp_valid[g] next cycle, and returns to IDLE.
- Round robin: the priority pointer is the last granted index. Search starts at last+1 mod NREQ. After reset, requester 0 has highest priority. The pointer updates only on grant.
- No back-to-back SETUP. At least one IDLE cycle separates transfers. The IDLE cycle in which rsp_valid is high may grant the next command.
- Requests that change while not accepted are ignored; requesters must hold them stable.
- All outputs except req_ready are registered.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, pointer=NREQ-1.

## Timing
- Zero-wait transfer: accept at cycle 0, SETUP at cycle 1, ACCESS with PREADY at cycle 2, rsp_valid at cycle 3. Minimum latency from req_ready to rsp_valid is 3 cycles. Each PREADY-low cycle adds 1.
- Simultaneous req_valid from all requesters: grants rotate 0,1,…,NREQ-1,0.
- Requester that keeps req_valid high after its response: it is not regranted while another is pending (fairness).
- PRESETn low mid-transfer: PSEL/PENABLE drop asynchronously, no rsp_valid is issued, the command is lost, the pointer is reset.
- PSLVERR is sampled only in the ACCESS cycle with PREADY=1.

## Configuration
- Macro APB_MASTER_ARB_TIMEOUT_EN.
- Defined: a wait counter clears on ACCESS entry and increments on each ACCESS cycle with PREADY=0. If PREADY is still 0 when the counter reaches TIMEOUT_CYCLES, the transfer ends in that cycle: PSEL/PENABLE drop next cycle, rsp_valid[g] pulses with rsp_err=1 and rsp_rdata=0, and the FSM returns to IDLE.
- Undefined: no counter; ACCESS waits indefinitely and TIMEOUT_CYCLES is unused.

## Structure
- Package apb_master_arb_pkg: state typedef (IDLE/SETUP/ACCESS), default widths, default TIMEOUT_CYCLES.
- Sub-module rr_arbiter: NREQ request vector plus pointer in, one-hot grant and index out, purely combinational. The FSM, APB drive and response logic stay in the top module.

## Test plan
- Requester 0 writes 0xA5 to addr 0 with PREADY=1 -> SETUP cycle 1, ACCESS cycle 2 with PADDR=0 and PWDATA=0xA5, rsp_valid[0] cycle 3, rsp_err=0.
- Requester 1 reads addr 5 with PRDATA=0x3C -> rsp_rdata=0x3C and rsp_valid[1] 3 cycles after accept.
- Both requesters valid continuously, 4 commands each -> grant order 0,1,0,1,…. No grant while a transfer is in flight.
- PREADY held low 3 cycles, then high with PSLVERR=1 (addr 0xF) -> latency 6 cycles, rsp_err=1.
- Timeout build with TIMEOUT_CYCLES=4 and PREADY stuck at 0 -> rsp_err=1 and rsp_rdata=0 after 4 ACCESS cycles. The FSM returns to IDLE and the next request is granted.
- PRESETn asserted during ACCESS -> PSEL/PENABLE=0 immediately, no rsp_valid. After release, requester 0 has priority.
